// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - pixel-stream sequencer and KxK window hand-off for the layer-0 conv stage
module conv_window_ctrl #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 3,
  parameter int COORD_W = 5,
  parameter int IDX_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               shift_en,
  output logic [COORD_W-1:0] pix_row,
  output logic [COORD_W-1:0] pix_col,
  output logic               win_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic [IDX_W-1:0]   win_idx,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] KM1      = COORD_W'(K - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] pix_row_q, pix_row_d;
  logic [COORD_W-1:0] pix_col_q, pix_col_d;
  logic               win_valid_q, win_valid_d;
  logic [COORD_W-1:0] win_row_q, win_row_d;
  logic [COORD_W-1:0] win_col_q, win_col_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [IDX_W-1:0]   win_cnt_q, win_cnt_d;

  logic slot_free;
  logic accept;

  // The window slot holds one entry; it frees up in the same cycle the MAC consumes it.
  assign slot_free  = !win_valid_q || out_ready;
  assign in_ready   = rst && (state_q == S_ACTIVE) && slot_free;
  assign accept     = in_valid && in_ready;
  assign shift_en   = accept;
  assign frame_done = rst && (state_q == S_FLUSH) && slot_free;
  assign busy       = (state_q == S_ACTIVE) || (state_q == S_FLUSH);

  assign pix_row   = pix_row_q;
  assign pix_col   = pix_col_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_idx   = win_idx_q;

  always_comb begin
    state_d     = state_q;
    pix_row_d   = pix_row_q;
    pix_col_d   = pix_col_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_idx_d   = win_idx_q;
    win_cnt_d   = win_cnt_q;

    if (win_valid_q && out_ready) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACTIVE;
          pix_row_d = '0;
          pix_col_d = '0;
          win_idx_d = '0;
          win_cnt_d = '0;
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          if (pix_col_q == LAST_COL) begin
            pix_col_d = '0;
            if (pix_row_q == LAST_ROW) begin
              pix_row_d = '0;
              state_d   = S_FLUSH;
            end else begin
              pix_row_d = pix_row_q + 1'b1;
            end
          end else begin
            pix_col_d = pix_col_q + 1'b1;
          end
          // A new window overrides the consume-clear above, so back-to-back windows have no bubble.
          if (pix_row_q >= KM1 && pix_col_q >= KM1) begin
            win_valid_d = 1'b1;
            win_row_d   = pix_row_q - KM1;
            win_col_d   = pix_col_q - KM1;
            win_idx_d   = win_cnt_q;
            win_cnt_d   = win_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_idx_q   <= '0;
      win_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_idx_q   <= win_idx_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - directed self-checking bench for conv_window_ctrl
module tb_conv_window_ctrl;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 3;
  localparam int COORD_W = 5;
  localparam int IDX_W   = 10;
  localparam int OW      = IMG_W - K + 1;
  localparam int NWIN    = (IMG_H - K + 1) * OW;
  localparam int NPIX    = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic               shift_en;
  logic [COORD_W-1:0] pix_row;
  logic [COORD_W-1:0] pix_col;
  logic               win_valid;
  logic               out_ready;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic [IDX_W-1:0]   win_idx;
  logic               busy;
  logic               frame_done;

  int total = 0;
  int bad   = 0;

  int acc, nwin, ndone, seq_err;
  int win_acc [NWIN];
  int last_row, last_col, last_idx;
  logic s_in_ready, s_shift, s_fd;

  always #5 clk = ~clk;

  conv_window_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .COORD_W(COORD_W), .IDX_W(IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .win_valid (win_valid),
    .out_ready (out_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_idx   (win_idx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    acc = 0; nwin = 0; ndone = 0; seq_err = 0;
    last_row = -1; last_col = -1; last_idx = -1;
    for (int i = 0; i < NWIN; i++) win_acc[i] = -1;
  endtask

  // One clock: drive inputs, sample at the falling edge, return just after the rising edge.
  task automatic cyc(input logic v, input logic r, input logic s);
    in_valid = v; out_ready = r; start = s;
    @(negedge clk);
    s_in_ready = in_ready;
    s_shift    = shift_en;
    s_fd       = frame_done;
    if (win_valid && out_ready) begin
      if (int'(win_row) != nwin / OW || int'(win_col) != nwin % OW || int'(win_idx) != nwin)
        seq_err++;
      if (nwin < NWIN) win_acc[nwin] = acc;
      last_row = win_row; last_col = win_col; last_idx = win_idx;
      nwin++;
    end
    if (shift_en) acc++;
    if (frame_done) ndone++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    bit wrap_done;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_counts();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    rst = 1'b1;

    check("rst_pix_row", pix_row, 0);
    check("rst_pix_col", pix_col, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_win_idx", win_idx, 0);

    // in_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    check("idle_in_ready", s_in_ready, 0);
    check("idle_shift", s_shift, 0);
    check("idle_acc", acc, 0);
    check("idle_busy", busy, 0);

    // Frame 1: streaming, no back-pressure
    clear_counts();
    wrap_done = 0;
    cyc(0, 1, 1);
    check("start_busy", busy, 1);
    budget = 0;
    while (ndone == 0 && budget < 3000) begin
      cyc(1, 1, 0);
      budget++;
      if (acc == IMG_W && !wrap_done) begin
        wrap_done = 1;
        check("wrap_pix_row", pix_row, 1);
        check("wrap_pix_col", pix_col, 0);
      end
    end
    check("f1_timeout", budget < 3000, 1);
    check("f1_accepts", acc, NPIX);
    check("f1_windows", nwin, NWIN);
    check("f1_seq_err", seq_err, 0);
    check("f1_first_win_acc", win_acc[0], 59);
    check("f1_win25_acc", win_acc[25], 84);
    check("f1_win26_acc", win_acc[26], 87);
    check("f1_last_row", last_row, 25);
    check("f1_last_col", last_col, 25);
    check("f1_last_idx", last_idx, 675);
    check("f1_done_cnt", ndone, 1);
    check("f1_idle_busy", busy, 0);
    cyc(0, 1, 0);
    check("f1_done_once", ndone, 1);

    // Frame 2: back-pressure on the first window, then stalled flush
    clear_counts();
    cyc(0, 0, 1);
    budget = 0;
    while (!win_valid && budget < 200) begin
      cyc(1, 0, 0);
      budget++;
    end
    check("bp_win_seen", win_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      check("bp_in_ready", s_in_ready, 0);
      check("bp_shift", s_shift, 0);
      check("bp_win_valid", win_valid, 1);
      check("bp_win_row", win_row, 0);
      check("bp_win_col", win_col, 0);
      check("bp_win_idx", win_idx, 0);
    end
    check("bp_acc_held", acc, 59);
    cyc(1, 1, 0);
    check("bp_release_ready", s_in_ready, 1);
    check("bp_release_shift", s_shift, 1);
    check("bp_next_col", win_col, 1);
    check("bp_next_idx", win_idx, 1);
    budget = 0;
    while (acc < NPIX && budget < 2000) begin
      cyc(1, 1, 0);
      budget++;
    end
    check("f2_accepts", acc, NPIX);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      check("fl_busy", busy, 1);
      check("fl_no_done", s_fd, 0);
      check("fl_in_ready", s_in_ready, 0);
      check("fl_win_idx", win_idx, 675);
    end
    cyc(0, 1, 0);
    check("fl_done", s_fd, 1);
    check("fl_idle", busy, 0);
    check("f2_windows", nwin, NWIN);
    check("f2_seq_err", seq_err, 0);

    // Frame 3: start ignored mid-frame, then reset mid-frame
    clear_counts();
    cyc(0, 1, 1);
    budget = 0;
    while (acc < 100 && budget < 500) begin
      cyc(1, 1, 0);
      budget++;
    end
    cyc(0, 1, 1);
    check("act_start_row", pix_row, 100 / IMG_W);
    check("act_start_col", pix_col, 100 % IMG_W);
    check("act_start_shift", s_shift, 0);
    check("act_start_busy", busy, 1);
    while (acc < 300 && budget < 1000) begin
      cyc(1, 1, 0);
      budget++;
    end
    check("mid_acc", acc, 300);
    rst = 1'b0;
    cyc(1, 1, 0);
    check("mid_rst_in_ready", s_in_ready, 0);
    check("mid_rst_shift", s_shift, 0);
    rst = 1'b1;
    check("mid_pix_row", pix_row, 0);
    check("mid_pix_col", pix_col, 0);
    check("mid_win_valid", win_valid, 0);
    check("mid_win_row", win_row, 0);
    check("mid_win_col", win_col, 0);
    check("mid_win_idx", win_idx, 0);
    check("mid_busy", busy, 0);

    clear_counts();
    cyc(0, 1, 1);
    budget = 0;
    while (nwin == 0 && budget < 200) begin
      cyc(1, 1, 0);
      budget++;
    end
    check("re_first_win_acc", win_acc[0], 59);
    check("re_first_row", last_row, 0);
    check("re_first_col", last_col, 0);
    check("re_first_idx", last_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the layer-0 convolution input stage. Accepts a raster-order 8-bit pixel stream over a valid/ready handshake and drives the line-buffer shift enable.
- Tracks the row/column of each accepted pixel and declares when a complete KxK window is present in the line buffer.
- Hands each window to the downstream MAC engine with its output coordinates, applying back-pressure when that engine stalls.
- Sits between the image source and the line buffer / convolution datapath, one frame per `start`.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 3, kernel size (KxK window)
- COORD_W, 5, width of row/column coordinates; must hold max(IMG_W, IMG_H)-1
- IDX_W, 10, width of window index; must hold (IMG_H-K+1)*(IMG_W-K+1)-1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  source has a pixel
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  line-buffer write/shift strobe; equals in_valid & in_ready (combinational)
- pix_row  out  COORD_W  row of the next pixel to be accepted
- pix_col  out  COORD_W  column of the next pixel to be accepted
- win_valid  out  1  a complete window is presented to the MAC
- out_ready  in  1  MAC consumes the window this cycle
- win_row  out  COORD_W  output-map row of the presented window
- win_col  out  COORD_W  output-map column of the presented window
- win_idx  out  IDX_W  raster index of the presented window (0-based)
- busy  out  1  high in ACTIVE and FLUSH
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0 at a clock edge) forces IDLE from any state, including mid-frame.
- Reset values: pix_row, pix_col, win_row, win_col and win_idx are 0; win_valid, busy and frame_done are 0.
- in_ready is 0 in IDLE, FLUSH and under reset.
- States are IDLE, ACTIVE and FLUSH.
- IDLE -> ACTIVE: when start=1. pix_row, pix_col and win_idx clear to 0. start is ignored in all other states.
- ACTIVE, handshake: in_ready = !win_valid | out_ready (single-entry window slot). An accept is in_valid & in_ready.
- ACTIVE, pixel counters on accept:
  - pix_col increments.
  - At pix_col = IMG_W-1 it wraps to 0 and pix_row increments.
- ACTIVE, window detection: on accept of pixel (r,c) with r >= K-1 and c >= K-1:
  - Next cycle win_valid=1, win_row=r-(K-1), win_col=c-(K-1).
  - win_idx holds the current window count, and the count increments.
- Window slot: win_valid and the win_* outputs hold stable until out_ready=1.
- Simultaneous consume and new window in the same cycle: the new window replaces the old one with no bubble, and win_valid stays 1.
- Consume with no new window: win_valid <= 0.
- ACTIVE -> FLUSH: on accept of pixel (IMG_H-1, IMG_W-1).
- FLUSH: no pixel accepts. When the slot is empty (win_valid=0, or win_valid & out_ready this cycle), frame_done=1 for one cycle, then the next state is IDLE.
- Pixels not forming a window (r < K-1 or c < K-1) still assert shift_en but produce no window.
- Frame totals: IMG_W*IMG_H accepts and (IMG_H-K+1)*(IMG_W-K+1) windows; defaults are 784 accepts and 676 windows.
- With the defaults, the first window follows the 59th accepted pixel (index 58, at (2,2)).
- in_valid while in IDLE is ignored: no accept and no shift_en.
- Latency: accept to win_valid is 1 cycle.

Test Plan:
- Back-to-back frame, reset, start pulse, in_valid held high, out_ready=1:
  - First win_valid arrives 1 cycle after the 59th accept, with win_row=0, win_col=0, win_idx=0.
  - Exactly 676 windows, last one win_row=25, win_col=25, win_idx=675.
  - frame_done pulses once, then IDLE.
- Row wrap: after the 28th accept, pix_row=1 and pix_col=0. No window is emitted for the accepts at (3,0) and (3,1); the next window is (1,0) on the accept of (3,2).
- Back-pressure: hold out_ready=0 for 5 cycles while win_valid=1.
  - in_ready=0 for those cycles, win_* stable, no shift_en.
  - On release, the held window is consumed and the next accept proceeds in the same cycle.
- Flush: hold out_ready=0 when the final pixel is accepted. The state stays in FLUSH with busy=1 and no frame_done until out_ready=1, then frame_done pulses.
- Reset mid-frame: drive rst=0 after 300 accepts.
  - All outputs return to reset values.
  - A new start yields first window at (0,0) with win_idx=0.
- start during ACTIVE and in_valid during IDLE are both ignored: no counter change, no shift_en.
